// File: rtl/parity_up_down_counter_pkg.sv
// Shared encodings for the parity up/down counter: count-set selection and direction.
package parity_up_down_counter_pkg;

    // Count-set selection; the reserved code behaves like PAR_ALL.
    typedef enum logic [1:0] {
        PAR_ALL  = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } par_sel_e;

    // Counting direction as seen on the mode input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Fold the reserved selection code onto PAR_ALL so downstream logic sees three cases only.
    function automatic par_sel_e norm_par_sel(input logic [1:0] sel);
        par_sel_e s;
        s = par_sel_e'(sel);
        if (s == PAR_RSVD) begin
            s = PAR_ALL;
        end
        return s;
    endfunction

endpackage

// File: rtl/parity_step_calc.sv
// Combinational step engine: terminal value, next count value and boundary-crossing flag.
module parity_step_calc
    import parity_up_down_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic             mode_i,
    input  logic [1:0]       par_sel_i,
    input  logic             sat_i,
    output logic [WIDTH-1:0] term_o,
    output logic [WIDTH-1:0] next_o,
    output logic             wrapped_o
);

    par_sel_e         sel;
    logic             mismatch;
    logic [WIDTH:0]   stepAmt;
    logic [WIDTH:0]   curExt;
    logic [WIDTH:0]   result;
    logic             crossed;

    // Terminal value depends only on direction and count set.
    always_comb begin
        sel    = norm_par_sel(par_sel_i);
        term_o = '0;
        if (mode_i == DIR_UP) begin
            if (sel == PAR_EVEN) begin
                term_o = {{(WIDTH-1){1'b1}}, 1'b0};
            end else begin
                term_o = {WIDTH{1'b1}};
            end
        end else begin
            if (sel == PAR_ODD) begin
                term_o = {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                term_o = '0;
            end
        end
    end

    // One extra bit catches carry/borrow so a crossing of 0 or all-ones is visible; a wrong-parity value takes a single alignment step of 1.
    always_comb begin
        mismatch  = ((sel == PAR_EVEN) && cur_i[0]) || ((sel == PAR_ODD) && !cur_i[0]);
        stepAmt   = ((sel == PAR_ALL) || mismatch) ? (WIDTH+1)'(1) : (WIDTH+1)'(2);
        curExt    = {1'b0, cur_i};
        if (mode_i == DIR_UP) begin
            result = curExt + stepAmt;
        end else begin
            result = curExt - stepAmt;
        end
        crossed   = result[WIDTH];
        next_o    = result[WIDTH-1:0];
        wrapped_o = crossed;
        if (crossed && sat_i) begin
            next_o    = term_o;
            wrapped_o = 1'b0;
        end
    end

endmodule

// File: rtl/parity_up_down_counter.sv
// Up/down counter over all, even-only or odd-only values, with wrap or saturate at the boundaries.
module parity_up_down_counter
    import parity_up_down_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             mode,
    input  logic [1:0]       par_sel,
    input  logic             sat,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] termVal;
    logic [WIDTH-1:0] stepNext;
    logic             stepWrapped;
    par_sel_e         sel;

    parity_step_calc #(
        .WIDTH(WIDTH)
    ) u_step (
        .cur_i    (count_q),
        .mode_i   (mode),
        .par_sel_i(par_sel),
        .sat_i    (sat),
        .term_o   (termVal),
        .next_o   (stepNext),
        .wrapped_o(stepWrapped)
    );

    // Next-state selection: load beats enable, and the wrap pulse only survives a wrapping step.
    always_comb begin
        sel     = norm_par_sel(par_sel);
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = data_in;
            if (sel == PAR_EVEN) begin
                count_d[0] = 1'b0;
            end else if (sel == PAR_ODD) begin
                count_d[0] = 1'b1;
            end
        end else if (en) begin
            count_d = stepNext;
            wrap_d  = stepWrapped;
        end
    end

    // Count and wrap registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign data_out = count_q;
    assign wrap     = wrap_q;
    assign tc       = (count_q == termVal);

endmodule

// File: tb/tb_parity_up_down_counter.sv
// Directed bench for parity_up_down_counter at WIDTH=4 with hand-computed expectations.
module tb_parity_up_down_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [3:0] data_in;
    logic       mode;
    logic [1:0] par_sel;
    logic       sat;
    logic [3:0] data_out;
    logic       tc;
    logic       wrap;

    int total;
    int bad;

    parity_up_down_counter #(
        .WIDTH(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .data_in (data_in),
        .mode    (mode),
        .par_sel (par_sel),
        .sat     (sat),
        .data_out(data_out),
        .tc      (tc),
        .wrap    (wrap)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset values, tc under two directions, and an asynchronous mid-count reset at value 6.
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0; data_in = 4'd0;
        mode = 1'b1; par_sel = 2'b01; sat = 1'b0;
        #1;
        total++; if (data_out !== 4'd0) begin bad++; $display("[TB] FAIL reset_data got=%0d want=0", data_out); end
        total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL reset_wrap got=%0b want=0", wrap); end
        total++; if (tc !== 1'b0) begin bad++; $display("[TB] FAIL reset_tc_up_even got=%0b want=0", tc); end
        mode = 1'b0;
        #1;
        total++; if (tc !== 1'b1) begin bad++; $display("[TB] FAIL reset_tc_down_even got=%0b want=1", tc); end
        mode = 1'b1;
        tick();
        rst_n = 1'b1;
        en = 1'b1;
        tick();
        tick();
        tick();
        total++; if (data_out !== 4'd6) begin bad++; $display("[TB] FAIL pre_reset_count got=%0d want=6", data_out); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (data_out !== 4'd0) begin bad++; $display("[TB] FAIL async_reset_data got=%0d want=0", data_out); end
        total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_wrap got=%0b want=0", wrap); end
        #1;
        rst_n = 1'b1;
        tick();
        total++; if (data_out !== 4'd2) begin bad++; $display("[TB] FAIL post_reset_step got=%0d want=2", data_out); end
        en = 1'b0;
    endtask

    // Even-only up count from a forced-even load, through the wrap at the top.
    task automatic test_even_up_wrap();
        load = 1'b1; en = 1'b1; data_in = 4'd3; par_sel = 2'b01; mode = 1'b1; sat = 1'b0;
        tick();
        total++; if (data_out !== 4'd2) begin bad++; $display("[TB] FAIL even_load got=%0d want=2", data_out); end
        total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL even_load_wrap got=%0b want=0", wrap); end
        load = 1'b0;
        for (int exp = 4; exp <= 14; exp += 2) begin
            tick();
            total++; if (data_out !== 4'(exp)) begin bad++; $display("[TB] FAIL even_up got=%0d want=%0d", data_out, exp); end
            total++; if (tc !== (exp == 14)) begin bad++; $display("[TB] FAIL even_up_tc at=%0d got=%0b want=%0b", exp, tc, (exp == 14)); end
            total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL even_up_wrap at=%0d got=%0b want=0", exp, wrap); end
        end
        tick();
        total++; if (data_out !== 4'd0) begin bad++; $display("[TB] FAIL even_wrap_value got=%0d want=0", data_out); end
        total++; if (wrap !== 1'b1) begin bad++; $display("[TB] FAIL even_wrap_pulse got=%0b want=1", wrap); end
        en = 1'b0;
        tick();
        total++; if (data_out !== 4'd0) begin bad++; $display("[TB] FAIL hold_value got=%0d want=0", data_out); end
        total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL wrap_one_cycle got=%0b want=0", wrap); end
    endtask

    // Odd-only down count saturating at 1.
    task automatic test_odd_down_sat();
        load = 1'b1; en = 1'b0; data_in = 4'd5; par_sel = 2'b10; mode = 1'b0; sat = 1'b1;
        tick();
        total++; if (data_out !== 4'd5) begin bad++; $display("[TB] FAIL odd_load got=%0d want=5", data_out); end
        load = 1'b0; en = 1'b1;
        tick();
        total++; if (data_out !== 4'd3) begin bad++; $display("[TB] FAIL odd_down_3 got=%0d want=3", data_out); end
        total++; if (tc !== 1'b0) begin bad++; $display("[TB] FAIL odd_down_tc3 got=%0b want=0", tc); end
        tick();
        total++; if (data_out !== 4'd1) begin bad++; $display("[TB] FAIL odd_down_1 got=%0d want=1", data_out); end
        total++; if (tc !== 1'b1) begin bad++; $display("[TB] FAIL odd_down_tc1 got=%0b want=1", tc); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (data_out !== 4'd1) begin bad++; $display("[TB] FAIL odd_sat_hold got=%0d want=1", data_out); end
            total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL odd_sat_wrap got=%0b want=0", wrap); end
        end
        en = 1'b0;
    endtask

    // Switching from even to odd mid-run takes one alignment step of 1.
    task automatic test_align();
        load = 1'b1; en = 1'b0; data_in = 4'd6; par_sel = 2'b01; mode = 1'b1; sat = 1'b0;
        tick();
        total++; if (data_out !== 4'd6) begin bad++; $display("[TB] FAIL align_load got=%0d want=6", data_out); end
        load = 1'b0; en = 1'b1; par_sel = 2'b10;
        tick();
        total++; if (data_out !== 4'd7) begin bad++; $display("[TB] FAIL align_step got=%0d want=7", data_out); end
        tick();
        total++; if (data_out !== 4'd9) begin bad++; $display("[TB] FAIL align_next9 got=%0d want=9", data_out); end
        tick();
        total++; if (data_out !== 4'd11) begin bad++; $display("[TB] FAIL align_next11 got=%0d want=11", data_out); end
        en = 1'b0;
    endtask

    // Load wins over enable on the same edge; reserved selection behaves like all-values.
    task automatic test_back_to_back();
        load = 1'b1; en = 1'b1; data_in = 4'd9; par_sel = 2'b00; mode = 1'b1; sat = 1'b0;
        tick();
        total++; if (data_out !== 4'd9) begin bad++; $display("[TB] FAIL load_priority got=%0d want=9", data_out); end
        load = 1'b0;
        tick();
        total++; if (data_out !== 4'd10) begin bad++; $display("[TB] FAIL after_load_step got=%0d want=10", data_out); end
        load = 1'b1; data_in = 4'd7; par_sel = 2'b11;
        tick();
        total++; if (data_out !== 4'd7) begin bad++; $display("[TB] FAIL rsvd_load got=%0d want=7", data_out); end
        load = 1'b0;
        tick();
        total++; if (data_out !== 4'd8) begin bad++; $display("[TB] FAIL rsvd_step got=%0d want=8", data_out); end
        en = 1'b0;
        tick();
        total++; if (data_out !== 4'd8) begin bad++; $display("[TB] FAIL hold_no_en got=%0d want=8", data_out); end
    endtask

    // All-values down count: wrap 0 -> 15, then saturate at 0.
    task automatic test_all_down();
        load = 1'b1; en = 1'b0; data_in = 4'd0; par_sel = 2'b00; mode = 1'b0; sat = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        total++; if (data_out !== 4'd15) begin bad++; $display("[TB] FAIL down_wrap_value got=%0d want=15", data_out); end
        total++; if (wrap !== 1'b1) begin bad++; $display("[TB] FAIL down_wrap_pulse got=%0b want=1", wrap); end
        tick();
        total++; if (data_out !== 4'd14) begin bad++; $display("[TB] FAIL down_after_wrap got=%0d want=14", data_out); end
        total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL down_wrap_clear got=%0b want=0", wrap); end
        load = 1'b1; en = 1'b0; data_in = 4'd0; sat = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        total++; if (data_out !== 4'd0) begin bad++; $display("[TB] FAIL down_sat_value got=%0d want=0", data_out); end
        total++; if (tc !== 1'b1) begin bad++; $display("[TB] FAIL down_sat_tc got=%0b want=1", tc); end
        total++; if (wrap !== 1'b0) begin bad++; $display("[TB] FAIL down_sat_wrap got=%0b want=0", wrap); end
        en = 1'b0;
    endtask

    // Run every scenario in order and report.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_even_up_wrap();
        test_odd_down_sat();
        test_align();
        test_back_to_back();
        test_all_down();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_up_down_counter.md
PARITY_UP_DOWN_COUNTER -- requirements
Module: parity_up_down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits, legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  count enable.
REQ-005 SHALL have port load  input  1  synchronous load strobe.
REQ-006 SHALL have port data_in  input  WIDTH  load value.
REQ-007 SHALL have port mode  input  1  direction: 1 = up, 0 = down.
REQ-008 SHALL have port par_sel  input  2  count set: 00 all values, 01 even only, 10 odd only, 11 treated as 00.
REQ-009 SHALL have port sat  input  1  boundary policy: 0 = wrap, 1 = saturate.
REQ-010 SHALL have port data_out  output  WIDTH  registered count.
REQ-011 SHALL have port tc  output  1  terminal count, combinational from data_out, mode and par_sel.
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse when a count step wrapped.

Function
REQ-013 SHALL apply priority: rst_n low > load > en > hold.
REQ-014 On load, SHALL set data_out to data_in with LSB forced to 0 (even) or 1 (odd), unmodified for all; load SHALL clear wrap.
REQ-015 On en with data_out parity matching par_sel, SHALL step by 1 (all) or 2 (even/odd), up or down per mode.
REQ-016 On en with parity mismatch (par_sel changed mid-run), SHALL take one alignment step of 1 in the mode direction; subsequent steps follow REQ-015.
REQ-017 Terminal value SHALL be: up all/odd 2^WIDTH-1, up even 2^WIDTH-2, down all/even 0, down odd 1.
REQ-018 tc SHALL be 1 exactly when data_out equals the terminal value for current mode and par_sel.
REQ-019 With sat=0, a step crossing 0 or 2^WIDTH-1 SHALL wrap modulo 2^WIDTH and assert wrap for the following cycle only.
REQ-020 With sat=1, a step that would cross a boundary SHALL instead set data_out to the current terminal value; wrap SHALL stay 0.
REQ-021 With en=0 and load=0, data_out SHALL hold and wrap SHALL be 0.
REQ-022 mode, par_sel and sat changes SHALL take effect on the next enabled edge, no extra latency.

Reset
REQ-023 While rst_n low, data_out SHALL be 0 and wrap 0, immediately and independent of clk.
REQ-024 Reset asserted mid-count SHALL abandon the step in progress; first post-release edge SHALL act on value 0.
REQ-025 tc after reset SHALL follow REQ-018 (e.g. 1 for down/even, 0 for up/even).

Structure
REQ-026 Shared package SHALL hold par_sel encodings (PAR_ALL, PAR_EVEN, PAR_ODD) and direction constants (DIR_UP, DIR_DOWN).
REQ-027 Terminal-value and next-value arithmetic SHALL be one combinational sub-module parity_step_calc; counter register and wrap flag stay in the top.
REQ-028 Internal arithmetic SHALL use WIDTH+1 bits to detect boundary crossing.

Verification (WIDTH=4)
REQ-029 rst_n low at t=0, mode=1, par_sel=01 -> data_out=0, wrap=0, tc=0; pulse rst_n low mid-count at value 6 -> data_out=0 asynchronously.
REQ-030 load data_in=3, par_sel=01, mode=1, sat=0, en=1 -> 2,4,...,14 (tc=1 at 14), then 0 with wrap=1 one cycle.
REQ-031 load 5, par_sel=10, mode=0, sat=1 -> 3,1 (tc=1), holds 1 on further enables, wrap never 1.
REQ-032 at data_out=6 par_sel=01 mode=1, switch par_sel=10 -> 7 (alignment), 9, 11.
REQ-033 load=1 and en=1 same edge, data_in=9, par_sel=00 -> data_out=9, no step; next edge up -> 10.
REQ-034 par_sel=00 mode=0 sat=0 from 0 -> 15 with wrap=1; sat=1 from 0 -> stays 0, tc=1.
